// File: rtl/adder_share_ctrl.sv
// adder_share_ctrl: two requesters share one ripple-carry adder.
// A round-robin arbiter picks one operand pair in IDLE, the pair is added
// in ADD and the result is held on the shared response channel in RESP
// until the consumer accepts it.
module adder_share_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             busy,
    output logic [CNT_W-1:0] op_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic             last_grant;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;

    logic             grant_valid;
    logic             grant_id;
    logic             handshake;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    logic [WIDTH-1:0] add_sum;
    logic [WIDTH:1]   carry;

    // Round-robin choice: on contention the requester not served last wins,
    // otherwise whichever one is asking. Ready is held low during reset.
    always_comb begin
        grant_valid = req0_valid | req1_valid;
        grant_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_id = ~last_grant;
        end else if (req1_valid) begin
            grant_id = 1'b1;
        end
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (rst_n && state == IDLE && grant_valid) begin
            req0_ready = ~grant_id;
            req1_ready = grant_id;
        end
        handshake = req0_ready | req1_ready;
        sel_a     = grant_id ? req1_a : req0_a;
        sel_b     = grant_id ? req1_b : req0_b;
    end

    // Bit 0 of the shared adder is a half adder; there is no carry in.
    always_comb begin
        add_sum[0] = a_q[0] ^ b_q[0];
        carry[1]   = a_q[0] & b_q[0];
    end

    // Remaining bits are full adders rippling the carry towards the MSB.
    for (genvar i = 1; i < WIDTH; i++) begin : g_full_adder
        always_comb begin
            add_sum[i]   = a_q[i] ^ b_q[i] ^ carry[i];
            carry[i+1]   = (a_q[i] & b_q[i]) | (carry[i] & (a_q[i] ^ b_q[i]));
        end
    end

    // Capture/add/respond sequencer with registered response and status
    // outputs; reset drops any operation in flight without a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
            busy       <= 1'b0;
            op_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (handshake) begin
                        a_q        <= sel_a;
                        b_q        <= sel_b;
                        id_q       <= grant_id;
                        last_grant <= grant_id;
                        busy       <= 1'b1;
                        state      <= ADD;
                    end
                end
                ADD: begin
                    rsp_sum   <= add_sum;
                    rsp_cout  <= carry[WIDTH];
                    rsp_id    <= id_q;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        op_cnt    <= op_cnt + CNT_ONE;
                        state     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_ctrl.sv
// tb_adder_share_ctrl: directed and random operations on adder_share_ctrl
// compared against a plain-arithmetic model of arbitration, sums and count.
module tb_adder_share_ctrl;

    localparam int WIDTH = 4;
    localparam int CNT_W = 2;

    logic             clk;
    logic             rst_n;
    logic             req0_valid;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_sum;
    logic             rsp_cout;
    logic             busy;
    logic [CNT_W-1:0] op_cnt;

    int testsRun;
    int testsFailed;

    // Reference state: who was served last and how many ops completed.
    int modelLast;
    int modelCount;

    adder_share_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req0_valid(req0_valid),
        .req0_a(req0_a),
        .req0_b(req0_b),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_a(req1_a),
        .req1_b(req1_b),
        .req1_ready(req1_ready),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
        .rsp_sum(rsp_sum),
        .rsp_cout(rsp_cout),
        .busy(busy),
        .op_cnt(op_cnt)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkIdle();
        checkOutput("idle_busy", 32'(busy), 32'd0);
        checkOutput("idle_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("idle_op_cnt", 32'(op_cnt), 32'(modelCount % (1 << CNT_W)));
    endtask

    // One complete operation starting in IDLE just after a rising edge.
    // Valids stay asserted through the busy cycles; stall cycles of
    // backpressure are applied in RESP before the response is accepted.
    task automatic applyStimulus(input logic v0, input int a0, input int b0,
                                 input logic v1, input int a1, input int b1,
                                 input int stall);
        int grantId;
        int total;
        int expSum;
        int expCout;
        req0_valid = v0; req0_a = WIDTH'(a0); req0_b = WIDTH'(b0);
        req1_valid = v1; req1_a = WIDTH'(a1); req1_b = WIDTH'(b1);
        if (v0 && v1) grantId = 1 - modelLast;
        else          grantId = v1 ? 1 : 0;
        total   = grantId == 1 ? (a1 + b1) : (a0 + b0);
        expSum  = total % (1 << WIDTH);
        expCout = total >= (1 << WIDTH) ? 1 : 0;

        @(negedge clk);
        checkIdle();
        checkOutput("grant_ready0", 32'(req0_ready), 32'(grantId == 0));
        checkOutput("grant_ready1", 32'(req1_ready), 32'(grantId == 1));
        @(posedge clk); #1;
        modelLast = grantId;

        @(negedge clk);
        checkOutput("add_busy", 32'(busy), 32'd1);
        checkOutput("add_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("add_ready", 32'({req0_ready, req1_ready}), 32'd0);
        @(posedge clk); #1;

        for (int i = 0; i <= stall; i++) begin
            if (i == stall) rsp_ready = 1'b1;
            @(negedge clk);
            checkOutput("rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("rsp_busy", 32'(busy), 32'd1);
            checkOutput("rsp_id", 32'(rsp_id), 32'(grantId));
            checkOutput("rsp_sum", 32'(rsp_sum), 32'(expSum));
            checkOutput("rsp_cout", 32'(rsp_cout), 32'(expCout));
            checkOutput("rsp_ready_low", 32'({req0_ready, req1_ready}), 32'd0);
            checkOutput("rsp_op_cnt", 32'(op_cnt), 32'(modelCount % (1 << CNT_W)));
            @(posedge clk); #1;
        end
        modelCount++;
        rsp_ready  = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_ready"}, 32'({req0_ready, req1_ready}), 32'd0);
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_rsp_data"}, 32'({rsp_id, rsp_sum, rsp_cout}), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_op_cnt"}, 32'(op_cnt), 32'd0);
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        modelLast   = 1;
        modelCount  = 0;
        rst_n      = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0;
        rsp_ready  = 1'b0;

        // Power-on reset.
        @(negedge clk);
        checkResetValues("por");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single requester and overflow corners.
        applyStimulus(1'b1, 3, 5, 1'b0, 0, 0, 0);
        applyStimulus(1'b0, 0, 0, 1'b1, 9, 12, 0);
        applyStimulus(1'b1, 15, 15, 1'b0, 0, 0, 0);
        applyStimulus(1'b0, 0, 0, 1'b1, 0, 0, 0);

        // Contention: both requesters asking for four operations.
        applyStimulus(1'b1, 1, 2, 1'b1, 7, 8, 0);
        applyStimulus(1'b1, 4, 6, 1'b1, 7, 8, 0);
        applyStimulus(1'b1, 4, 6, 1'b1, 11, 13, 0);
        applyStimulus(1'b1, 2, 14, 1'b1, 11, 13, 0);

        // Backpressure for five cycles in RESP.
        applyStimulus(1'b1, 6, 9, 1'b0, 0, 0, 5);

        // Reset during ADD discards the operation.
        req0_valid = 1'b1; req0_a = 4'd10; req0_b = 4'd3;
        @(posedge clk); #1;
        checkOutput("midop_in_add", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        checkResetValues("midop");
        modelLast  = 1;
        modelCount = 0;
        @(negedge clk);
        req0_valid = 1'b0;
        rst_n      = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("midop_no_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk); #1;
        applyStimulus(1'b1, 3, 4, 1'b0, 0, 0, 0);

        // Random traffic, at least one requester valid per operation.
        for (int n = 0; n < 24; n++) begin
            int sel;
            sel = int'($urandom_range(1, 3));
            applyStimulus(sel[0], int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          sel[1], int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                          int'($urandom_range(0, 3)));
        end

        @(negedge clk);
        checkIdle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/adder_share_ctrl.md
# adder_share_ctrl

Controller that shares one WIDTH-bit ripple adder (half adder on bit 0, full adders above, carry out) between two requesters. Each requester presents an operand pair with a valid/ready handshake. A round-robin arbiter grants one request at a time and sequences it through a capture/add/respond FSM. The result, carry and requester ID are returned on a single shared response channel. The block sits between client logic and the arithmetic datapath, so no client ever drives the adder directly.

## Interface
- WIDTH, 4, operand and sum width in bits (≥2)
- CNT_W, 8, width of the completed-operation counter
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has an operand pair
- req0_a, req0_b  input  WIDTH each  requester 0 operands
- req0_ready  output  1  requester 0 operands accepted this cycle
- req1_valid  input  1  requester 1 has an operand pair
- req1_a, req1_b  input  WIDTH each  requester 1 operands
- req1_ready  output  1  requester 1 operands accepted this cycle
- rsp_valid  output  1  response available
- rsp_ready  input  1  response consumer accepts
- rsp_id  output  1  requester that owns the response (0/1)
- rsp_sum  output  WIDTH  a+b modulo 2^WIDTH
- rsp_cout  output  1  carry out of the MSB
- busy  output  1  FSM not in IDLE
- op_cnt  output  CNT_W  completed responses, wraps at 2^CNT_W

## Operation
- FSM states: IDLE, ADD, RESP.
- IDLE:
  - if any reqN_valid, grant one requester and assert its reqN_ready combinationally (same cycle as valid); the other ready stays 0
  - on the handshake, latch a, b and the id, then go to ADD
  - with no valid, stay in IDLE
- ADD: the internal adder computes the latched a+b; register sum/cout into rsp_sum/rsp_cout; go to RESP.
- RESP:
  - rsp_valid=1; rsp_id/rsp_sum/rsp_cout stay stable until rsp_valid && rsp_ready
  - on acceptance: op_cnt+1 (wraps), go to IDLE
  - otherwise hold RESP indefinitely
- Arbitration:
  - a 1-bit last_grant register, reset to 1, so requester 0 wins the first contention
  - when both valid in IDLE, grant !last_grant; when only one is valid, grant it
  - update last_grant to the granted id on each handshake
- Both reqN_ready are 0 outside IDLE.
- Arithmetic: full WIDTH-bit unsigned add with carry; rsp_sum = (a+b) mod 2^WIDTH; rsp_cout = (a+b) ≥ 2^WIDTH.
- Reset at any time (mid-operation included):
  - state=IDLE; all outputs return to reset values immediately
  - the in-flight operation is discarded with no response
  - last_grant=1
- Reset values:
  - req0_ready=0, req1_ready=0 (a valid in the first post-reset cycle may then raise its ready)
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0
  - busy=0, op_cnt=0

## Timing
- Cycle T: handshake in IDLE.
- T+1: ADD, busy=1.
- T+2: RESP, rsp_valid=1.
- If rsp_ready=1 at T+2: IDLE at T+3, and the next handshake can happen at T+3. Peak throughput is 1 op per 3 cycles.
- Latency from handshake to first rsp_valid: 2 cycles.
- A requester whose valid drops before the handshake is simply not served. Requesters must hold valid and operands until ready.
- rsp_ready asserted while rsp_valid=0 has no effect.
- busy=1 in ADD and RESP.
- A valid arriving while busy waits; arbitration happens only in IDLE.

## Test plan
- Reset, then req0 a=3, b=5 alone:
  - req0_ready=1 same cycle
  - rsp_valid 2 cycles later with id=0, sum=8, cout=0
  - op_cnt=1 after rsp_ready
- Overflow: req1 a=9, b=12 -> sum=5, cout=1, id=1. Also a=15, b=15 -> sum=14, cout=1; a=0, b=0 -> sum=0, cout=0.
- Contention: both valid continuously from reset with distinct operands:
  - grants alternate 0,1,0,1 over 4 ops
  - rsp_id sequence 0,1,0,1, each sum correct
- Backpressure: hold rsp_ready=0 for 5 cycles in RESP:
  - rsp_valid and data stable throughout
  - both reqN_ready=0 throughout
  - accepted on the 6th cycle, op_cnt increments exactly once
- Reset mid-op: assert rst_n=0 during ADD:
  - outputs immediately at reset values, no response produced
  - after release, a new req0 3+4 returns sum=7
- Counter wrap with CNT_W=2: 5 completed ops -> op_cnt reads 1,2,3,0,1.
